// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the shared 6-digit hex display with a minimum dwell per grant; optional HEX_LZ_BLANK_EN blanks leading zeros.
// Latency: req -> grant/disp_value 1 cycle; live value tracking 1 cycle; all outputs registered.
// Backpressure: none; requesters hold req level and simply wait until the round robin reaches them.
module hex_display_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int IDX_W       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [NUM_SRC*24-1:0] value_in,
    output logic [NUM_SRC-1:0]    grant,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic [23:0]           disp_value,
    output logic [5:0]            disp_blank
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last, last_nxt, owner_nxt, winner;
    logic               win_vld;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic [23:0]        value_nxt;
    logic [5:0]         blank_nxt;
    int                 idx;

`ifdef HEX_LZ_BLANK_EN
    // Digit k is blanked when it and every more significant digit are zero.
    function automatic logic [5:0] lz_blank(input logic [23:0] v);
        logic [5:0] b;
        logic       zero;
        b    = 6'h00;
        zero = 1'b1;
        for (int k = 5; k >= 1; k--) begin
            zero = zero & (v[4*k +: 4] == 4'h0);
            b[k] = zero;
        end
        return b;
    endfunction
`endif

    // Scan from the highest offset down so the nearest requester after last wins.
    // The current owner sits at offset NUM_SRC, so any other requester beats it.
    always_comb begin
        winner  = last;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (req[idx]) begin
                winner  = IDX_W'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        value_nxt = disp_value;
        blank_nxt = 6'h3f;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = SHOW;
                    owner_nxt = winner;
                    last_nxt  = winner;
                    cnt_nxt   = CNT_RELOAD;
                    grant_nxt = NUM_SRC'(1) << winner;
                    value_nxt = value_in[24*winner +: 24];
                end
            end
            SHOW: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                    if (req[owner]) begin
                        value_nxt = value_in[24*owner +: 24];
                    end
                end else if (win_vld) begin
                    owner_nxt = winner;
                    last_nxt  = winner;
                    cnt_nxt   = CNT_RELOAD;
                    grant_nxt = NUM_SRC'(1) << winner;
                    value_nxt = value_in[24*winner +: 24];
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == SHOW) begin
`ifdef HEX_LZ_BLANK_EN
            blank_nxt = lz_blank(value_nxt);
`else
            blank_nxt = 6'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last       <= IDX_W'(NUM_SRC - 1);
            cnt        <= '0;
            disp_value <= 24'h0;
            disp_blank <= 6'h3f;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            owner      <= owner_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            disp_value <= value_nxt;
            disp_blank <= blank_nxt;
        end
    end

    assign busy = (state == SHOW);

endmodule
